// File: rtl/simt_icache_pkg.sv
// Shared OpenGPU constants and the instruction-cache state type.
package pkg_opengpu;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam logic [INSTR_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

  localparam int unsigned ICACHE_LINES      = 16;
  localparam int unsigned ICACHE_LINE_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_REQ,
    REFILL_WAIT,
    RESPOND
  } icache_state_t;

endpackage

// File: rtl/simt_icache_data_ram.sv
// Instruction data store: one synchronous write port, one asynchronous read port.
module simt_icache_data_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/simt_icache.sv
// Direct-mapped instruction cache with blocking line refill from backing memory.
module simt_icache
  import pkg_opengpu::*;
#(
  parameter int unsigned NUM_LINES  = ICACHE_LINES,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   imem_req,
  input  logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   imem_valid,
  input  logic                   icache_inv,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [INSTR_WIDTH-1:0] mem_resp_data,
  output logic                   busy,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
);

  localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W   = $clog2(NUM_LINES);
  localparam int unsigned TAG_LSB = OFF_W + IDX_W + 2;
  localparam int unsigned TAG_W   = ADDR_WIDTH - TAG_LSB;

  icache_state_t r_state, w_next;

  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [OFF_W-1:0]       r_beat_cnt;
  logic [NUM_LINES-1:0]   r_valid;
  logic [TAG_W-1:0]       r_tag [NUM_LINES];
  logic                   r_inv_pending;

  logic [OFF_W-1:0]       w_off;
  logic [IDX_W-1:0]       w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic                   w_hit;
  logic                   w_beat;
  logic                   w_last_beat;
  logic [INSTR_WIDTH-1:0] w_ram_rdata;
  logic                   w_unused;

  assign w_off    = r_addr[OFF_W+1:2];
  assign w_idx    = r_addr[TAG_LSB-1:OFF_W+2];
  assign w_tag    = r_addr[ADDR_WIDTH-1:TAG_LSB];
  assign w_unused = ^r_addr[1:0];

  // An invalidate arriving with the lookup wins over a stale hit.
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !icache_inv;
  assign w_beat      = (r_state == REFILL_WAIT) && mem_resp_valid;
  assign w_last_beat = w_beat && (r_beat_cnt == OFF_W'(LINE_WORDS - 1));

  assign mem_req_valid = (r_state == REFILL_REQ);
  assign busy          = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (imem_req) w_next = LOOKUP;
      LOOKUP:      w_next = w_hit ? IDLE : REFILL_REQ;
      REFILL_REQ:  if (mem_req_ready) w_next = REFILL_WAIT;
      REFILL_WAIT: if (w_last_beat) w_next = RESPOND;
      RESPOND:     w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_beat_cnt    <= '0;
      r_valid       <= '0;
      r_inv_pending <= 1'b0;
      imem_valid    <= 1'b0;
      imem_rdata    <= INSTR_NOP;
      mem_req_addr  <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      imem_valid <= 1'b0;
      if (r_state == IDLE && imem_req) r_addr <= imem_addr;
      if (r_state == LOOKUP) begin
        if (w_hit) begin
          imem_rdata <= w_ram_rdata;
          imem_valid <= 1'b1;
          hit_count  <= hit_count + 32'd1;
        end else begin
          miss_count    <= miss_count + 32'd1;
          mem_req_addr  <= {r_addr[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
          r_inv_pending <= 1'b0;
        end
      end
      // Remember an invalidate seen mid-refill so the finished line stays invalid.
      if ((r_state inside {REFILL_REQ, REFILL_WAIT}) && icache_inv) r_inv_pending <= 1'b1;
      if (w_beat) r_beat_cnt <= r_beat_cnt + OFF_W'(1);
      if (r_state == RESPOND) begin
        imem_rdata <= w_ram_rdata;
        imem_valid <= 1'b1;
      end
      if (icache_inv)                            r_valid        <= '0;
      else if (w_last_beat && !r_inv_pending)    r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_last_beat) r_tag[w_idx] <= w_tag;
  end

  simt_icache_data_ram #(
    .DEPTH (NUM_LINES * LINE_WORDS),
    .WIDTH (INSTR_WIDTH)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_beat),
    .i_waddr ({w_idx, r_beat_cnt}),
    .i_wdata (mem_resp_data),
    .i_raddr ({w_idx, w_off}),
    .o_rdata (w_ram_rdata)
  );

endmodule

// File: tb/tb_simt_icache.sv
// Randomised scoreboard bench for simt_icache against a line-presence cache model.
module tb_simt_icache;
  import pkg_opengpu::*;

  localparam int unsigned LW = ICACHE_LINE_WORDS;
  localparam int unsigned NL = ICACHE_LINES;

  logic        clk = 1'b0;
  logic        rst_n, imem_req;
  logic [31:0] imem_addr, imem_rdata, mem_req_addr, mem_resp_data;
  logic        imem_valid, icache_inv, mem_req_valid, mem_req_ready, mem_resp_valid, busy;
  logic [31:0] hit_count, miss_count;

  logic        r_ready, r_rv, r_inv, m_ready, m_rv, t_inv;
  logic [31:0] r_rdata, m_rdata;

  assign mem_req_ready  = r_ready | m_ready;
  assign mem_resp_valid = r_rv | m_rv;
  assign mem_resp_data  = r_rv ? r_rdata : m_rdata;
  assign icache_inv     = r_inv | t_inv;

  simt_icache #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .icache_inv(icache_inv),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    bit          is_hit;
    int unsigned req_cyc;
  } exp_t;
  exp_t sb[$];

  int unsigned n_checks = 0, n_pass = 0, overlap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Backing memory contents: fixed per word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a - (a % 4);
    if (w >= 32'h100 && w < 32'h110) return 32'hA0 + (w - 32'h100) / 4;
    return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Cache model: which memory line each index currently holds.
  bit          m_valid[NL];
  logic [31:0] m_tag[NL];
  int unsigned m_hits = 0, m_misses = 0;

  int          g_delay = 0, g_gap = 0, g_inv_beat = -1;
  logic [31:0] g_exp_line = '0;
  bit          g_manual = 1'b0;
  int unsigned g_req_events = 0;

  // Backing-memory responder.
  initial begin
    r_ready = 1'b0; r_rv = 1'b0; r_rdata = '0; r_inv = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && !g_manual) begin
        logic [31:0] a;
        bit          stable;
        a = mem_req_addr;
        g_req_events++;
        check("req_addr", a, g_exp_line);
        stable = 1'b1;
        for (int i = 0; i < g_delay; i++) begin
          @(negedge clk);
          if (!mem_req_valid || mem_req_addr !== a) stable = 1'b0;
        end
        if (g_delay > 0) check("req_stable", 32'(stable), 32'd1);
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        for (int b = 0; b < int'(LW); b++) begin
          for (int g = 0; g < g_gap; g++) @(negedge clk);
          r_rv    = 1'b1;
          r_rdata = mem_word(a + 32'(4 * b));
          r_inv   = (b == g_inv_beat);
          @(negedge clk);
          r_rv  = 1'b0;
          r_inv = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_valid && mem_req_valid) overlap++;
      if (imem_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_resp: got imem_valid with rdata 0x%08h, expected none", imem_rdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rdata", imem_rdata, e.data);
          if (e.is_hit) check("hit_latency", cyc - e.req_cyc, 32'd2);
          check("busy_at_resp", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input int delay, input int gap, input int inv_beat);
    int unsigned idx, ev0, t;
    logic [31:0] tag;
    bit          hit;
    exp_t        e;
    idx = (a / (4 * LW)) % NL;
    tag = a / (4 * LW * NL);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    ev0 = g_req_events;
    g_delay = delay; g_gap = gap; g_inv_beat = hit ? -1 : inv_beat;
    g_exp_line = a - (a % (4 * LW));
    e.data = mem_word(a); e.is_hit = hit; e.req_cyc = cyc;
    sb.push_back(e);
    imem_addr = a; imem_req = 1'b1;
    @(negedge clk);
    imem_req = 1'b0; imem_addr = $urandom;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
      // A second request while the cache is busy refilling must be dropped.
      imem_req = (!hit && t == 1);
      if (imem_req) imem_addr = $urandom;
    end
    imem_req = 1'b0;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL resp_timeout: no response for addr 0x%08h within 300 cycles", a);
      sb.delete();
    end
    @(negedge clk);
    if (hit) m_hits++;
    else begin
      m_misses++;
      m_tag[idx] = tag;
      m_valid[idx] = 1'b1;
      if (inv_beat >= 0) m_valid = '{default: 1'b0};
    end
    check("rdata_hold", imem_rdata, e.data);
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
    check("refill_reqs", g_req_events - ev0, hit ? 32'd0 : 32'd1);
  endtask

  task automatic idle_inv();
    t_inv = 1'b1;
    @(negedge clk);
    t_inv = 1'b0;
    m_valid = '{default: 1'b0};
  endtask

  task automatic check_reset_outputs(input string tagname);
    check({tagname, "_imem_valid"}, 32'(imem_valid), 32'd0);
    check({tagname, "_imem_rdata"}, imem_rdata, INSTR_NOP);
    check({tagname, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tagname, "_mem_req_addr"}, mem_req_addr, 32'd0);
    check({tagname, "_busy"}, 32'(busy), 32'd0);
    check({tagname, "_hit_count"}, hit_count, 32'd0);
    check({tagname, "_miss_count"}, miss_count, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t;
    rst_n = 1'b0; imem_req = 1'b0; imem_addr = '0;
    m_ready = 1'b0; m_rv = 1'b0; m_rdata = '0; t_inv = 1'b0;
    m_valid = '{default: 1'b0};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    fetch(32'h100, 0, 0, -1);
    fetch(32'h108, 0, 0, -1);
    fetch(32'h500, 0, 0, -1);
    fetch(32'h100, 1, 1, -1);
    fetch(32'h20C, 5, 2, -1);
    fetch(32'h20C, 0, 0, -1);
    fetch(32'h344, 0, 1, 2);
    fetch(32'h344, 0, 0, -1);
    fetch(32'h344, 0, 0, -1);
    fetch(32'h3F8, 2, 0, 3);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 11) == 0) idle_inv();
      fetch(a, $urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LW - 1)) : -1);
    end

    // Reset while the refill is half delivered.
    g_manual = 1'b1;
    imem_addr = 32'h600; imem_req = 1'b1;
    @(negedge clk);
    imem_req = 1'b0;
    t = 0;
    while (!mem_req_valid && t < 20) begin @(negedge clk); t++; end
    check("rst_req_seen", 32'(mem_req_valid), 32'd1);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_rv = 1'b1; m_rdata = mem_word(32'h600 + 32'(4 * b));
      @(negedge clk);
      m_rv = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    for (int b = 2; b < int'(LW); b++) begin
      m_rv = 1'b1; m_rdata = 32'hDEAD_0000 + 32'(b);
      @(negedge clk);
      m_rv = 1'b0;
      @(negedge clk);
    end
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_rdata", imem_rdata, INSTR_NOP);
    m_valid = '{default: 1'b0};
    m_hits = 0; m_misses = 0;
    g_manual = 1'b0;
    fetch(32'h600, 0, 0, -1);
    fetch(32'h604, 0, 0, -1);

    check("imem_mem_overlap", overlap, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simt_icache.md
SIMT_ICACHE -- requirements
Module: simt_icache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 16; number of direct-mapped lines, power of two.
REQ-002 SHALL have parameter LINE_WORDS, default 4; INSTR_WIDTH words per line, power of two.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port imem_req  input  1  fetch request pulse; imem_addr valid this cycle.
REQ-006 SHALL have port imem_addr  input  ADDR_WIDTH  fetch byte address.
REQ-007 SHALL have port imem_rdata  output  INSTR_WIDTH  returned instruction; holds until next response.
REQ-008 SHALL have port imem_valid  output  1  one-cycle response strobe.
REQ-009 SHALL have port icache_inv  input  1  invalidate all lines.
REQ-010 SHALL have port mem_req_valid  output  1  refill request to backing memory.
REQ-011 SHALL have port mem_req_ready  input  1  backing memory accepts request.
REQ-012 SHALL have port mem_req_addr  output  ADDR_WIDTH  line-aligned refill address.
REQ-013 SHALL have port mem_resp_valid  input  1  refill beat valid.
REQ-014 SHALL have port mem_resp_data  input  INSTR_WIDTH  refill beat data, word 0 first.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-016 SHALL have ports hit_count, miss_count  output  32  free-running wrap-around counters.

Function
REQ-017 Address split SHALL be: bits[1:0] ignored, word offset log2(LINE_WORDS) bits, index log2(NUM_LINES) bits, remainder tag.
REQ-018 States SHALL be IDLE, LOOKUP, REFILL_REQ, REFILL_WAIT, RESPOND.
REQ-019 IDLE: imem_req high latches imem_addr, next state LOOKUP; imem_req outside IDLE SHALL be ignored.
REQ-020 LOOKUP hit (valid bit set, tag equal): imem_rdata <= stored word, imem_valid high next cycle for one cycle, hit_count+1, return to IDLE; hit latency exactly 2 cycles from imem_req.
REQ-021 LOOKUP miss: miss_count+1, next state REFILL_REQ.
REQ-022 REFILL_REQ: mem_req_valid high with mem_req_addr = latched address with offset and bits[1:0] zeroed; held stable until the cycle mem_req_ready is high, then REFILL_WAIT.
REQ-023 REFILL_WAIT: each mem_resp_valid beat writes data[index][beat_cnt], beat_cnt+1; after beat LINE_WORDS-1, beat_cnt wraps to 0, tag written, valid bit set, next state RESPOND.
REQ-024 RESPOND: imem_rdata <= refilled requested word, imem_valid high one cycle, next state IDLE.
REQ-025 mem_resp_valid outside REFILL_WAIT SHALL be ignored; mem_resp_valid gaps SHALL be tolerated.
REQ-026 icache_inv SHALL clear all valid bits at the next edge in any state; no state transition caused.
REQ-027 icache_inv during REFILL_REQ/REFILL_WAIT: refill completes, response delivered, line SHALL NOT be marked valid.
REQ-028 icache_inv in the same cycle as LOOKUP SHALL force miss.
REQ-029 Refill into an index SHALL overwrite any previous tag (no victim writeback).
REQ-030 imem_valid and mem_req_valid SHALL never be high in the same cycle.

Reset
REQ-031 On rst_n low at clock edge: state IDLE, all valid bits 0, beat_cnt 0, imem_valid 0, imem_rdata INSTR_NOP, mem_req_valid 0, mem_req_addr 0, counters 0.
REQ-032 Reset mid-refill SHALL abandon the refill; subsequent beats ignored; line left invalid.
REQ-033 Data and tag arrays SHALL NOT require reset.

Structure
REQ-034 pkg_opengpu SHALL hold ICACHE_LINES, ICACHE_LINE_WORDS defaults and icache_state_t enum; INSTR_NOP, INSTR_WIDTH, ADDR_WIDTH reused from it.
REQ-035 Data storage SHALL be one sub-module simt_icache_data_ram: NUM_LINES*LINE_WORDS x INSTR_WIDTH, one write port, one read port.

Verification
REQ-036 Cold miss: imem_addr 0x100, memory returns 0xA0,0xA1,0xA2,0xA3 -> mem_req_addr 0x100, imem_rdata 0xA0, miss_count 1.
REQ-037 Hit: then imem_addr 0x108 -> imem_valid exactly 2 cycles after imem_req, imem_rdata 0xA2, hit_count 1, no mem_req_valid.
REQ-038 Conflict: imem_addr 0x500 (same index, new tag) -> refill; then 0x100 misses again, miss_count 3.
REQ-039 Backpressure: mem_req_ready low 5 cycles, response beats with 2-cycle gaps -> mem_req_addr stable, correct word returned.
REQ-040 Invalidate mid-refill at beat 2 -> response delivered; re-request same address misses.
REQ-041 Reset asserted in REFILL_WAIT -> all outputs at reset values next cycle; later beats ignored; next request misses.
